keypad_press_scanner: RTL and testbench
=======================================

# keypad_press_scanner

Keypad scan front end that drives the four keypad columns one at a time and samples the four row sense lines. It debounces a detected press with an up/down counter and emits one key code per press as a single-cycle pulse. It then holds the column fixed until every row has read released for a full debounce interval. The block sits between the synchronized keypad pins and the display/key-handling logic. It is the press-side counterpart of the release detection used by the scan controller.

## Interface
- `SETTLE`, default 4: cycles each column is driven before rows are sampled; must be ≥1.
- `PRESS_TOP`, default 16: debounce ceiling; must be an even number ≥2.
- `RELEASE_TOP`, default 16: number of consecutive all-released cycles that ends a hold; must be ≥1.
- `clk`, input, 1 bit: the single clock.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `sense`, input, 4 bits: row lines, active-high (1 = pressed). Already synchronized to `clk`.
- `col`, output, 4 bits: one-hot, active-high column drive.
- `key`, output, 4 bits: last accepted key code, encoded as row×4 + col index.
- `key_valid`, output, 1 bit: one-cycle pulse when a new `key` is accepted.
- `holding`, output, 1 bit: high in the EMIT and HOLD states.

## Operation
- Reset values:
  - state = SCAN, column index = 0, `col` = 4'b0001
  - settle count = 0, debounce count = PRESS_TOP/2, release count = 0
  - `key` = 0, `key_valid` = 0, `holding` = 0
- `col` is always one-hot and equals 1 << column index.
- **SCAN**
  - The settle counter counts 0 … SETTLE-1.
  - On the cycle where the count equals SETTLE-1, the block samples `sense`:
    - Any bit set: latch row = index of the lowest set bit, load debounce count = PRESS_TOP/2, go to DEBOUNCE.
    - No bit set: column index ← (index+1) mod 4 (3 wraps to 0), settle count ← 0.
- **DEBOUNCE**
  - The column is frozen.
  - Each cycle:
    - If `sense[row]` = 1: count + 1.
    - Else: count − 1.
  - If `sense[row]` = 1 and count = PRESS_TOP-1: go to EMIT.
  - If `sense[row]` = 0 and count = 1: abandon the press. Column index advances by 1, settle count ← 0, go to SCAN.
  - Other row bits are ignored.
- **EMIT**
  - Lasts exactly one cycle.
  - `key_valid` = 1 and `key` = {row, col index} are both visible in this cycle.
  - Release count ← 0. Next state is HOLD.
- **HOLD**
  - The column is frozen.
  - If `sense` = 0: release count + 1. Any set bit (any row): release count ← 0.
  - When `sense` = 0 and release count = RELEASE_TOP-1: go to SCAN. Column index advances by 1, settle count ← 0.
- `key` keeps its value until the next EMIT. It is never cleared except by reset.
- `key_valid` is high only in EMIT, so at most one pulse is produced per press.
- Counter widths:
  - Debounce counter: $clog2(PRESS_TOP+1) bits.
  - Release counter: $clog2(RELEASE_TOP+1) bits.
  - Neither counter may overflow or underflow; the state transitions above guarantee this.
- Reset asserted in any state returns the block to its reset values on the next edge. No pulse is emitted that cycle.

## Timing
- Outputs are registered; there is no combinational path from `sense` to any output.
- Idle rotation: each column is driven for SETTLE cycles, so a full pass takes 4×SETTLE cycles.
- Cycle 0 is the first cycle after `reset` falls.
- Press latency, for a row already held steady on column c:
  - Sample cycle s = c×SETTLE + SETTLE-1.
  - DEBOUNCE is entered at s+1.
  - EMIT (`key_valid` high) occurs at s+1+PRESS_TOP/2.
- Release latency: SCAN resumes on the next column RELEASE_TOP cycles after the first all-zero cycle of an unbroken run within HOLD.

## Test plan
- **Idle rotation.** SETTLE=4, `sense`=0 for 32 cycles -> `col` goes 0001,0010,0100,1000, each for 4 cycles, then wraps to 0001 at cycle 16; `key_valid` never asserts.
- **Clean press.** SETTLE=4, PRESS_TOP=8, `sense`=4'b0100 (row 2) only while `col`=0010, held -> sample at cycle 7; `key_valid` high for exactly cycle 12 with `key`=9; `holding`=1 from cycle 12.
- **Bounce abandoned.** Same setup, `sense` drops to 0 at DEBOUNCE entry (cycle 8) -> count 4→0 by cycle 11, back to SCAN with `col`=0100 at cycle 12; no `key_valid`.
- **Multi-row priority.** `sense`=4'b1010 held on column 3 -> `key`=7 (row 1), single pulse.
- **Release glitch.** RELEASE_TOP=8 -> after EMIT, drop `sense` for 5 cycles, pulse it for 1 cycle, then hold 0 -> SCAN resumes on the next column exactly 8 cycles after the final zero run began; no second `key_valid`.
- **Reset mid-hold.** Assert `reset` for 1 cycle during HOLD -> next cycle `col`=0001, `key`=0, `holding`=0, `key_valid`=0.

Source files
------------

// File: rtl/keypad_press_scanner.sv
// Keypad press scanner: rotates a one-hot column drive, debounces the first
// row seen on a column, emits one key code per press and holds until release.
module keypad_press_scanner #(
  parameter int SETTLE      = 4,
  parameter int PRESS_TOP   = 16,
  parameter int RELEASE_TOP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sense,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       holding
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DW = $clog2(PRESS_TOP + 1);
  localparam int RW = $clog2(RELEASE_TOP + 1);

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
  localparam logic [DW-1:0] DB_INIT      = DW'(PRESS_TOP / 2);
  localparam logic [DW-1:0] DB_LAST      = DW'(PRESS_TOP - 1);
  localparam logic [DW-1:0] DB_ONE       = DW'(1);
  localparam logic [RW-1:0] RELEASE_LAST = RW'(RELEASE_TOP - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Handshake: none. key_valid is a one-cycle strobe with key stable in the
  // same cycle; there is no back-pressure, a consumer must take it then.
  state_t        state, state_nx;
  logic [1:0]    col_idx, col_idx_nx;
  logic [1:0]    row, row_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [DW-1:0] db_cnt, db_nx;
  logic [RW-1:0] rel_cnt, rel_nx;
  logic [3:0]    key_q, key_nx;

  // Lowest-numbered pressed row wins when several rows read active.
  function automatic logic [1:0] lowest_row(input logic [3:0] s);
    logic [1:0] r;
    r = 2'd0;
    if (s[3]) r = 2'd3;
    if (s[2]) r = 2'd2;
    if (s[1]) r = 2'd1;
    if (s[0]) r = 2'd0;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      row        <= 2'd0;
      settle_cnt <= '0;
      db_cnt     <= DB_INIT;
      rel_cnt    <= '0;
      key_q      <= 4'd0;
    end else begin
      state      <= state_nx;
      col_idx    <= col_idx_nx;
      row        <= row_nx;
      settle_cnt <= settle_nx;
      db_cnt     <= db_nx;
      rel_cnt    <= rel_nx;
      key_q      <= key_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    row_nx     = row;
    settle_nx  = settle_cnt;
    db_nx      = db_cnt;
    rel_nx     = rel_cnt;
    key_nx     = key_q;

    case (state)
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          if (|sense) begin
            row_nx   = lowest_row(sense);
            db_nx    = DB_INIT;
            state_nx = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
            settle_nx  = '0;
          end
        end else begin
          settle_nx = settle_cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (sense[row]) begin
          db_nx = db_cnt + 1'b1;
          if (db_cnt == DB_LAST) begin
            key_nx   = {row, col_idx};
            state_nx = EMIT;
          end
        end else begin
          db_nx = db_cnt - 1'b1;
          if (db_cnt == DB_ONE) begin
            col_idx_nx = col_idx + 2'd1;
            settle_nx  = '0;
            state_nx   = SCAN;
          end
        end
      end

      EMIT: begin
        rel_nx   = '0;
        state_nx = HOLD;
      end

      HOLD: begin
        // Any row activity restarts the release interval.
        if (sense == 4'd0) begin
          rel_nx = rel_cnt + 1'b1;
          if (rel_cnt == RELEASE_LAST) begin
            col_idx_nx = col_idx + 2'd1;
            settle_nx  = '0;
            state_nx   = SCAN;
          end
        end else begin
          rel_nx = '0;
        end
      end

      default: state_nx = SCAN;
    endcase
  end

  assign col       = 4'b0001 << col_idx;
  assign key       = key_q;
  assign key_valid = (state == EMIT);
  assign holding   = (state == EMIT) || (state == HOLD);

endmodule

// File: tb/tb_keypad_press_scanner.sv
// Directed and randomized bench for keypad_press_scanner against a
// cycle-level reference model built from the press/hold/release rules.
module tb_keypad_press_scanner;

  localparam int SETTLE      = 4;
  localparam int PRESS_TOP   = 8;
  localparam int RELEASE_TOP = 8;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sense;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       holding;

  always #5 clk = ~clk;

  keypad_press_scanner #(
    .SETTLE(SETTLE), .PRESS_TOP(PRESS_TOP), .RELEASE_TOP(RELEASE_TOP)
  ) dut (
    .clk(clk), .reset(reset), .sense(sense),
    .col(col), .key(key), .key_valid(key_valid), .holding(holding)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_valid = 0;

  // Reference model: phase name, current column, elapsed settle cycles,
  // latched row, debounce level, length of the current all-released run.
  localparam int PH_SCAN = 0, PH_DEB = 1, PH_EMIT = 2, PH_HOLD = 3;
  int m_phase, m_col, m_elapsed, m_row, m_level, m_zero_run, m_key;

  logic [3:0] obs_col, obs_key;
  logic       obs_kv, obs_hold;

  task automatic model_reset();
    m_phase = PH_SCAN; m_col = 0; m_elapsed = 0; m_row = 0;
    m_level = PRESS_TOP / 2; m_zero_run = 0; m_key = 0;
  endtask

  task automatic next_column();
    m_col = (m_col + 1) % 4;
    m_elapsed = 0;
    m_phase = PH_SCAN;
  endtask

  task automatic model_advance(input logic [3:0] s, input logic r);
    if (r) begin
      model_reset();
    end else begin
      case (m_phase)
        PH_SCAN:
          if (m_elapsed == SETTLE - 1) begin
            if (s != 0) begin
              for (int b = 3; b >= 0; b--) if (s[b]) m_row = b;
              m_level = PRESS_TOP / 2;
              m_phase = PH_DEB;
            end else next_column();
          end else m_elapsed++;
        PH_DEB:
          if (s[m_row]) begin
            if (m_level == PRESS_TOP - 1) begin
              m_key = m_row * 4 + m_col;
              m_phase = PH_EMIT;
            end
            m_level++;
          end else begin
            if (m_level == 1) next_column();
            m_level--;
          end
        PH_EMIT: begin
          m_zero_run = 0;
          m_phase = PH_HOLD;
        end
        default:
          if (s == 0) begin
            m_zero_run++;
            if (m_zero_run == RELEASE_TOP) next_column();
          end else m_zero_run = 0;
      endcase
    end
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Driver: one clock cycle with the given inputs; outputs checked mid-cycle.
  task automatic step(input logic [3:0] s, input logic r);
    logic [3:0] e_col;
    sense = s;
    reset = r;
    @(negedge clk);
    obs_col = col; obs_key = key; obs_kv = key_valid; obs_hold = holding;
    if (model_valid) begin
      e_col = 4'b0001 << m_col;
      chk("col", obs_col, e_col);
      chk("key", obs_key, 4'(m_key));
      chk("key_valid", {3'b0, obs_kv}, {3'b0, m_phase == PH_EMIT});
      chk("holding", {3'b0, obs_hold}, {3'b0, m_phase == PH_EMIT || m_phase == PH_HOLD});
    end
    @(posedge clk);
    model_advance(s, r);
    #1;
    cyc = r ? 0 : cyc + 1;
  endtask

  task automatic do_reset();
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    model_valid = 1;
  endtask

  int pulses;

  initial begin
    sense = 4'd0;
    reset = 1'b1;
    model_reset();

    // Idle rotation
    do_reset();
    chk("reset_col", col, 4'b0001);
    chk("reset_key", key, 4'd0);
    chk("reset_kv", {3'b0, key_valid}, 4'd0);
    pulses = 0;
    for (int c = 0; c < 32; c++) begin
      step(4'd0, 1'b0);
      if (obs_kv) pulses++;
      if (c == 3)  chk("idle_c3",  obs_col, 4'b0001);
      if (c == 4)  chk("idle_c4",  obs_col, 4'b0010);
      if (c == 11) chk("idle_c11", obs_col, 4'b0100);
      if (c == 12) chk("idle_c12", obs_col, 4'b1000);
      if (c == 16) chk("idle_wrap", obs_col, 4'b0001);
    end
    chk("idle_pulses", 4'(pulses), 4'd0);

    // Clean press on column 1, row 2, then release glitch
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step((c >= 4 && c < 16) || c == 21 ? 4'b0100 : 4'b0000, 1'b0);
      if (c == 11) chk("press_kv_c11", {3'b0, obs_kv}, 4'd0);
      if (c == 12) begin
        chk("press_kv_c12", {3'b0, obs_kv}, 4'd1);
        chk("press_key", obs_key, 4'd9);
        chk("press_hold", {3'b0, obs_hold}, 4'd1);
      end
      if (c == 13) chk("press_kv_c13", {3'b0, obs_kv}, 4'd0);
      if (c == 29) chk("glitch_still_hold", {3'b0, obs_hold}, 4'd1);
      if (c == 30) begin
        chk("glitch_release", {3'b0, obs_hold}, 4'd0);
        chk("glitch_col", obs_col, 4'b0100);
      end
      if (c > 13) chk("glitch_no_pulse", {3'b0, obs_kv}, 4'd0);
    end

    // Bounce abandoned at debounce entry
    do_reset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step((c >= 4 && c < 8) ? 4'b0100 : 4'b0000, 1'b0);
      if (obs_kv) pulses++;
      if (c == 11) chk("bounce_c11_col", obs_col, 4'b0010);
      if (c == 12) chk("bounce_col", obs_col, 4'b0100);
    end
    chk("bounce_pulses", 4'(pulses), 4'd0);

    // Multi-row priority on column 3, then reset mid-hold
    do_reset();
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      step(c >= 12 ? 4'b1010 : 4'b0000, 1'b0);
      if (obs_kv) pulses++;
      if (c == 20) chk("multi_kv", {3'b0, obs_kv}, 4'd1);
    end
    chk("multi_key", key, 4'd7);
    chk("multi_pulses", 4'(pulses), 4'd1);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b0);
    chk("rst_hold_col", obs_col, 4'b0001);
    chk("rst_hold_key", obs_key, 4'd0);
    chk("rst_hold_holding", {3'b0, obs_hold}, 4'd0);
    chk("rst_hold_kv", {3'b0, obs_kv}, 4'd0);

    // Randomized bursts against the model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      logic [3:0] v;
      int len;
      case ($urandom_range(0, 3))
        0: v = 4'd0;
        1: v = 4'd1 << $urandom_range(0, 3);
        default: v = 4'($urandom_range(0, 15));
      endcase
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) step(v, 1'b0);
      if ($urandom_range(0, 40) == 0) step(4'($urandom_range(0, 15)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
